// File: rtl/bsg_credit_pkg.sv
// Shared definitions for the credit sender/receiver pair: counter width helper,
// counter type and the up/down operation encoding.
package bsg_credit_pkg;

    localparam int credits_default_lp = 500;

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    typedef logic [credit_width(credits_default_lp)-1:0] credit_cnt_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_op_e;

endpackage

// File: rtl/bsg_credit_counter_up_down.sv
// Up/down credit counter. With BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN it saturates at
// max_val_p and flags overflow; otherwise it wraps in its own width.
module bsg_credit_counter_up_down
    import bsg_credit_pkg::*;
#(
    parameter int max_val_p  = 500,
    parameter int init_val_p = max_val_p,
    parameter int cw_p       = credit_width(max_val_p)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            up_i,
    input  logic            down_i,
`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
    output logic            overflow_o,
`endif
    output logic [cw_p-1:0] count_o
);

    localparam logic [cw_p-1:0] init_lp = cw_p'(init_val_p);
`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
    localparam logic [cw_p-1:0] max_lp  = cw_p'(max_val_p);
    logic overflow_s;
`endif

    cnt_op_e         op_s;
    logic [cw_p-1:0] count_d;
    logic [cw_p-1:0] count_q;

    // decode the simultaneous up/down request into a net operation
    always_comb begin
        op_s = CNT_HOLD;
        case ({up_i, down_i})
            2'b10:   op_s = CNT_INC;
            2'b01:   op_s = CNT_DEC;
            default: op_s = CNT_HOLD;
        endcase
    end

    // next count, saturating at the maximum when the overflow check is built in
    always_comb begin
        count_d = count_q;
`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
        overflow_s = 1'b0;
`endif
        case (op_s)
            CNT_INC: begin
`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
                if (count_q == max_lp) begin
                    overflow_s = 1'b1;
                    count_d    = count_q;
                end else begin
                    count_d    = count_q + cw_p'(1);
                end
`else
                count_d = count_q + cw_p'(1);
`endif
            end
            CNT_DEC:  count_d = count_q - cw_p'(1);
            CNT_HOLD: count_d = count_q;
            default:  count_d = count_q;
        endcase
    end

    // counter state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= init_lp;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
`ifndef SYNTHESIS
    // report each overflowing credit return in simulation
    always_ff @(posedge clk_i) begin
        if (!reset_i && overflow_s) begin
            $error("bsg_credit_sender: credit overflow at time %0t", $time);
        end
    end
`endif
    assign overflow_o = overflow_s;
`endif

    assign count_o = count_q;

endmodule

// File: rtl/bsg_credit_sender.sv
// Ready/valid to credit-based valid-only converter with registered output stage.
// Optional BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN adds a sticky overflow error.
module bsg_credit_sender
    import bsg_credit_pkg::*;
#(
    parameter int width_p   = 64,
    parameter int credits_p = 500,
    parameter int cw_p      = credit_width(credits_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               credit_i,
    output logic [cw_p-1:0]    credit_cnt_o,
    output logic               error_o
);

    logic               accept_s;
    logic [cw_p-1:0]    count_s;
    logic               v_d;
    logic               v_q;
    logic [width_p-1:0] data_d;
    logic [width_p-1:0] data_q;

`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
    logic overflow_s;
    logic error_d;
    logic error_q;
`endif

    bsg_credit_counter_up_down #(
        .max_val_p  (credits_p),
        .init_val_p (credits_p),
        .cw_p       (cw_p)
    ) counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .up_i       (credit_i),
        .down_i     (accept_s),
`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
        .overflow_o (overflow_s),
`endif
        .count_o    (count_s)
    );

    // readiness comes only from the registered count, so credit_i never bypasses
    assign ready_o  = (count_s != cw_p'(0));
    assign accept_s = v_i & ready_o;

    // output stage next-state: payload only moves on accept
    always_comb begin
        v_d = accept_s;
        if (accept_s) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // output register stage
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= {width_p{1'b0}};
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
    // sticky overflow flag, cleared only by reset
    always_comb begin
        if (overflow_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // overflow flag register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign v_o          = v_q;
    assign data_o       = data_q;
    assign credit_cnt_o = count_s;

endmodule

// File: tb/tb_bsg_credit_sender.sv
// Self-checking bench for bsg_credit_sender against an integer credit model.
module tb_bsg_credit_sender;

    localparam int W  = 64;
    localparam int CR = 500;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          credit_i = 1'b0;
    logic [CW-1:0] credit_cnt_o;
    logic          error_o;

    int errors = 0;
    int checks = 0;

    // reference model state
    int           m_cnt  = CR;
    bit           m_v    = 1'b0;
    logic [W-1:0] m_data = '0;
    bit           m_err  = 1'b0;
    int           m_accepts = 0;

    bsg_credit_sender #(.width_p(W), .credits_p(CR)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .credit_i(credit_i),
        .credit_cnt_o(credit_cnt_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    // one clock: drive inputs, advance the model by the credit rules, settle
    task automatic step(input bit v, input logic [W-1:0] d, input bit c, input bit r);
        bit acc;
        v_i = v; data_i = d; credit_i = c; reset_i = r;
        @(posedge clk);
        if (r) begin
            m_cnt = CR; m_v = 1'b0; m_data = '0; m_err = 1'b0;
        end else begin
            acc = v && (m_cnt != 0);
            if (c && !acc && m_cnt == CR) begin
`ifdef BSG_CREDIT_SENDER_OVERFLOW_CHECK_EN
                m_err = 1'b1;
`else
                m_cnt = (m_cnt + 1) % (1 << CW);
`endif
            end else begin
                m_cnt = m_cnt + int'(c) - int'(acc);
            end
            m_v = acc;
            if (acc) begin
                m_data = d;
                m_accepts++;
            end
        end
        #1;
        v_i = 1'b0; credit_i = 1'b0; reset_i = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        checks += 5;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", v_o); end
        if (credit_cnt_o !== CW'(CR)) begin errors++; $display("FAIL reset_cnt: got %0d want %0d", credit_cnt_o, CR); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", error_o); end
        if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    endtask

    task automatic test_burst_exhaust;
        int acc0 = m_accepts;
        for (int i = 0; i < 502; i++) begin
            checks++;
            if (ready_o !== (i < CR)) begin errors++; $display("FAIL burst_ready[%0d]: got %b want %b", i, ready_o, i < CR); end
            step(1'b1, W'(i < CR ? i : CR), 1'b0, 1'b0);
            checks += 2;
            if (v_o !== (i < CR)) begin errors++; $display("FAIL burst_v[%0d]: got %b want %b", i, v_o, i < CR); end
            if (data_o !== W'(i < CR ? i : CR - 1)) begin errors++; $display("FAIL burst_data[%0d]: got %0d want %0d", i, data_o, i < CR ? i : CR - 1); end
        end
        checks += 3;
        if (m_accepts - acc0 != CR) begin errors++; $display("FAIL burst_accepts: got %0d want %0d", m_accepts - acc0, CR); end
        if (credit_cnt_o !== CW'(0)) begin errors++; $display("FAIL burst_cnt: got %0d want 0", credit_cnt_o); end
        if (ready_o !== 1'b0) begin errors++; $display("FAIL burst_ready_end: got %b want 0", ready_o); end
    endtask

    task automatic test_credit_at_empty;
        step(1'b1, W'(CR), 1'b1, 1'b0);
        checks += 3;
        if (v_o !== 1'b0) begin errors++; $display("FAIL empty_nobypass_v: got %b want 0", v_o); end
        if (ready_o !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b want 1", ready_o); end
        if (credit_cnt_o !== CW'(1)) begin errors++; $display("FAIL empty_cnt1: got %0d want 1", credit_cnt_o); end
        step(1'b1, W'(CR), 1'b0, 1'b0);
        checks += 3;
        if (v_o !== 1'b1) begin errors++; $display("FAIL empty_accept_v: got %b want 1", v_o); end
        if (data_o !== W'(CR)) begin errors++; $display("FAIL empty_accept_data: got %0d want %0d", data_o, CR); end
        if (credit_cnt_o !== CW'(0)) begin errors++; $display("FAIL empty_cnt0: got %0d want 0", credit_cnt_o); end
        step(1'b1, W'(CR + 1), 1'b0, 1'b0);
        checks += 2;
        if (v_o !== 1'b0) begin errors++; $display("FAIL empty_single_v: got %b want 0", v_o); end
        if (data_o !== W'(CR)) begin errors++; $display("FAIL empty_hold_data: got %0d want %0d", data_o, CR); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (credit_cnt_o !== CW'(10)) begin errors++; $display("FAIL simul_setup_cnt: got %0d want 10", credit_cnt_o); end
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] d = {$urandom, $urandom};
            step(1'b1, d, 1'b1, 1'b0);
            checks += 3;
            if (credit_cnt_o !== CW'(10)) begin errors++; $display("FAIL simul_cnt[%0d]: got %0d want 10", i, credit_cnt_o); end
            if (v_o !== 1'b1) begin errors++; $display("FAIL simul_v[%0d]: got %b want 1", i, v_o); end
            if (data_o !== d) begin errors++; $display("FAIL simul_data[%0d]: got %h want %h", i, data_o, d); end
        end
    endtask

    task automatic test_overflow;
        while (m_cnt < CR) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (credit_cnt_o !== CW'(CR)) begin errors++; $display("FAIL ovf_setup_cnt: got %0d want %0d", credit_cnt_o, CR); end
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (error_o !== m_err) begin errors++; $display("FAIL ovf_err[%0d]: got %b want %b", i, error_o, m_err); end
            if (credit_cnt_o !== CW'(m_cnt)) begin errors++; $display("FAIL ovf_cnt[%0d]: got %0d want %0d", i, credit_cnt_o, m_cnt); end
            step(1'b0, '0, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (error_o !== 1'b0) begin errors++; $display("FAIL ovf_reset_err: got %b want 0", error_o); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1500; i++) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit c = (m_cnt < CR) && ($urandom_range(0, 2) != 0);
            checks++;
            if (ready_o !== (m_cnt != 0)) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ready_o, m_cnt != 0); end
            step(v, {$urandom, $urandom}, c, 1'b0);
            checks += 3;
            if (v_o !== m_v) begin errors++; $display("FAIL rand_v[%0d]: got %b want %b", i, v_o, m_v); end
            if (data_o !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, data_o, m_data); end
            if (credit_cnt_o !== CW'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, credit_cnt_o, m_cnt); end
        end
    endtask

    task automatic test_reset_mid_burst;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < CR - 37; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        checks += 2;
        if (credit_cnt_o !== CW'(37)) begin errors++; $display("FAIL mid_setup_cnt: got %0d want 37", credit_cnt_o); end
        if (v_o !== 1'b1) begin errors++; $display("FAIL mid_setup_v: got %b want 1", v_o); end
        step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
        checks += 4;
        if (v_o !== 1'b0) begin errors++; $display("FAIL mid_v: got %b want 0", v_o); end
        if (credit_cnt_o !== CW'(CR)) begin errors++; $display("FAIL mid_cnt: got %0d want %0d", credit_cnt_o, CR); end
        if (data_o !== '0) begin errors++; $display("FAIL mid_data: got %h want 0", data_o); end
        if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ready_o); end
    endtask

    initial begin
        test_reset;
        test_burst_exhaust;
        test_credit_at_empty;
        test_simultaneous;
        test_overflow;
        test_random;
        test_reset_mid_burst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
